// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, flag bit positions and FSM encodings for param_alu
// Rev 1.0
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_INV = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   localparam int OVF = 0;
   localparam int CRY = 1;
   localparam int NEG = 2;
   localparam int ZRO = 3;
   localparam int ERR = 4;
   localparam int NUM_FLAGS = 5;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MUL_RUN = 1'b1;

   typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/param_alu_if.sv
`default_nettype none
// ============================================================================
// param_alu_if : operation handshake and result bundle of param_alu
// Rev 1.0
// ============================================================================
interface param_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic [4:0]       flags;

   modport master (
      output in_valid, op, in1, in2,
      input  in_ready, out_valid, out, out_hi, flags
   );

   modport slave (
      input  in_valid, op, in1, in2,
      output in_ready, out_valid, out, out_hi, flags
   );

endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// alu_mul_seq : unsigned shift-add multiplier, one multiplier bit per cycle
// Rev 1.0
// ============================================================================
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  wire                 clk,
   input  wire                 reset,
   input  wire                 start,
   input  wire  [WIDTH-1:0]    a,
   input  wire  [WIDTH-1:0]    b,
   output logic                done,
   output logic [2*WIDTH-1:0]  product
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, add0, add1;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d, count_inc;
   logic               running_q, running_d;

   always_comb begin
      add0      = mplier_q[0] ? mcand_q : '0;
      add1      = mplier_q[1] ? (mcand_q << 1) : '0;
      count_inc = count_q + CW'(1);
      // The closing cycle folds the top two multiplier bits in together,
      // so the product is ready when count reaches WIDTH-1.
      done      = running_q && (count_inc == CW'(WIDTH-1));
      product   = acc_q + add0 + add1;

      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      running_d = running_q;
      if (start) begin
         mcand_d   = {{WIDTH{1'b0}}, a};
         mplier_d  = b;
         acc_d     = '0;
         count_d   = '0;
         running_d = 1'b1;
      end else if (running_q) begin
         mcand_d   = mcand_q << 1;
         mplier_d  = mplier_q >> 1;
         acc_d     = acc_q + add0;
         count_d   = count_inc;
         running_d = !done;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         running_q <= 1'b0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         running_q <= running_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/param_alu.sv
`default_nettype none
// ============================================================================
// param_alu : registered ALU with status flags, valid/ready input handshake
// Rev 1.0
// ============================================================================
module param_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input wire         clk,
   input wire         reset,
   param_alu_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   logic [0:0]         state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d, out_hi_q, out_hi_d;
   flags_t             flags_q, flags_d;
   logic               out_valid_q, out_valid_d;
   logic               accept, mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH-1:0]   res;
   logic               res_cry, res_ovf, res_err;
   logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
   logic [SHW-1:0]     amt;

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out       = out_q;
   assign bus.out_hi    = out_hi_q;
   assign bus.flags     = flags_q;
   assign bus.out_valid = out_valid_q;
   assign accept        = bus.in_valid && bus.in_ready;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (bus.in1),
      .b       (bus.in2),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath; the extra top/bottom bit of the shift results
   // holds the last bit shifted out.
   always_comb begin
      amt     = bus.in2[SHW-1:0];
      sum     = {1'b0, bus.in1} + {1'b0, bus.in2};
      diff    = {1'b0, bus.in1} - {1'b0, bus.in2};
      shl_ext = {1'b0, bus.in1} << amt;
      shr_ext = {bus.in1, 1'b0} >> amt;
      res     = '0;
      res_cry = 1'b0;
      res_ovf = 1'b0;
      res_err = 1'b0;
      case (bus.op)
         OP_ADD: begin
            res     = sum[MSB:0];
            res_cry = sum[WIDTH];
            res_ovf = (bus.in1[MSB] == bus.in2[MSB]) && (res[MSB] != bus.in1[MSB]);
         end
         OP_SUB: begin
            res     = diff[MSB:0];
            res_cry = diff[WIDTH];
            res_ovf = (bus.in1[MSB] != bus.in2[MSB]) && (res[MSB] != bus.in1[MSB]);
         end
         OP_AND: res = bus.in1 & bus.in2;
         OP_OR:  res = bus.in1 | bus.in2;
         OP_XOR: res = bus.in1 ^ bus.in2;
         OP_INV: res = ~bus.in1;
         OP_SHL: begin
            res     = shl_ext[MSB:0];
            res_cry = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res     = shr_ext[WIDTH:1];
            res_cry = shr_ext[0];
         end
         OP_MUL: ;
         default: res_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_hi_d    = out_hi_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      mul_start   = 1'b0;
      if (state_q == ST_IDLE) begin
         if (accept) begin
            if (bus.op == OP_MUL) begin
               mul_start = 1'b1;
               state_d   = ST_MUL_RUN;
            end else begin
               out_d        = res;
               out_hi_d     = '0;
               flags_d      = '0;
               flags_d[ERR] = res_err;
               flags_d[ZRO] = !res_err && (res == '0);
               flags_d[NEG] = res[MSB];
               flags_d[CRY] = res_cry;
               flags_d[OVF] = res_ovf;
               out_valid_d  = 1'b1;
            end
         end
      end else if (mul_done) begin
         out_d        = mul_product[MSB:0];
         out_hi_d     = mul_product[2*WIDTH-1:WIDTH];
         flags_d      = '0;
         flags_d[ZRO] = (mul_product == '0);
         flags_d[NEG] = mul_product[MSB];
         flags_d[OVF] = |mul_product[2*WIDTH-1:WIDTH];
         out_valid_d  = 1'b1;
         state_d      = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         out_hi_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_hi_q    <= out_hi_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_param_alu.sv
`default_nettype none
// ============================================================================
// tb_param_alu : directed vector table plus multiply / reset sequences, WIDTH=8
// Rev 1.0
// ============================================================================
module tb_param_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   param_alu_if #(.WIDTH(8)) bus ();

   param_alu #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic [4:0] f;
   } vec_t;

   vec_t vt [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] lo,
                         input logic [7:0] hi, input logic [4:0] fl, input string tag);
      int n;
      bus.op       = OP_MUL;
      bus.in1      = a;
      bus.in2      = b;
      bus.in_valid = 1'b1;
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd8);
      check({tag, "_lo"}, 32'(bus.out), 32'(lo));
      check({tag, "_hi"}, 32'(bus.out_hi), 32'(hi));
      check({tag, "_flags"}, 32'(bus.flags), 32'(fl));
      tick();
      check({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int pulses;
      // flags order {err, zero, neg, carry, ovf}
      vt[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b00101};
      vt[1]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 5'b00110};
      vt[2]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b01010};
      vt[3]  = '{OP_AND, 8'h37, 8'h5A, 8'h12, 5'b00000};
      vt[4]  = '{OP_OR,  8'h37, 8'h5A, 8'h7F, 5'b00000};
      vt[5]  = '{OP_XOR, 8'h37, 8'h5A, 8'h6D, 5'b00000};
      vt[6]  = '{OP_INV, 8'h37, 8'h5A, 8'hC8, 5'b00100};
      vt[7]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 5'b00010};
      vt[8]  = '{OP_SHR, 8'h81, 8'h09, 8'h40, 5'b00010};
      vt[9]  = '{OP_SHL, 8'h81, 8'h00, 8'h81, 5'b00100};
      vt[10] = '{4'hF,   8'h55, 8'hAA, 8'h00, 5'b10000};
      vt[11] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b00001};
      vt[12] = '{OP_SUB, 8'h33, 8'h33, 8'h00, 5'b01000};
      vt[13] = '{OP_SHR, 8'h81, 8'h07, 8'h01, 5'b00000};

      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.op       = OP_ADD;
      bus.in1      = '0;
      bus.in2      = '0;
      tick();
      tick();
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_out_hi", 32'(bus.out_hi), 32'd0);
      check("rst_flags", 32'(bus.flags), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      reset = 1'b1;
      tick();

      // Back-to-back single-cycle ops, one accepted per edge
      for (int i = 0; i < 14; i++) begin
         bus.in_valid = 1'b1;
         bus.op       = vt[i].op;
         bus.in1      = vt[i].a;
         bus.in2      = vt[i].b;
         check($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'd1);
         tick();
         check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("v%0d_out", i), 32'(bus.out), 32'(vt[i].y));
         check($sformatf("v%0d_out_hi", i), 32'(bus.out_hi), 32'd0);
         check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(vt[i].f));
      end
      bus.in_valid = 1'b0;
      tick();
      check("idle_valid", 32'(bus.out_valid), 32'd0);
      check("hold_out", 32'(bus.out), 32'h01);

      // MUL with a second op held while busy
      bus.op       = OP_MUL;
      bus.in1      = 8'h10;
      bus.in2      = 8'h20;
      bus.in_valid = 1'b1;
      tick();
      bus.op  = OP_ADD;
      bus.in1 = 8'h03;
      bus.in2 = 8'h04;
      for (int k = 1; k <= 7; k++) begin
         check($sformatf("busy%0d_ready", k), 32'(bus.in_ready), 32'd0);
         check($sformatf("busy%0d_valid", k), 32'(bus.out_valid), 32'd0);
         tick();
      end
      check("mul_valid", 32'(bus.out_valid), 32'd1);
      check("mul_ready", 32'(bus.in_ready), 32'd1);
      check("mul_lo", 32'(bus.out), 32'h00);
      check("mul_hi", 32'(bus.out_hi), 32'h02);
      check("mul_flags", 32'(bus.flags), 32'b00001);
      tick();
      bus.in_valid = 1'b0;
      check("held_valid", 32'(bus.out_valid), 32'd1);
      check("held_out", 32'(bus.out), 32'h07);
      check("held_out_hi", 32'(bus.out_hi), 32'h00);
      tick();
      check("held_once", 32'(bus.out_valid), 32'd0);

      do_mul(8'h00, 8'h55, 8'h00, 8'h00, 5'b01000, "mul_zero");
      do_mul(8'h0D, 8'h0B, 8'h8F, 8'h00, 5'b00100, "mul_small");
      do_mul(8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00001, "mul_max");

      // Reset three cycles into a MUL
      bus.op       = OP_MUL;
      bus.in1      = 8'h10;
      bus.in2      = 8'h20;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("arst_out", 32'(bus.out), 32'd0);
      check("arst_out_hi", 32'(bus.out_hi), 32'd0);
      check("arst_flags", 32'(bus.flags), 32'd0);
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_ready", 32'(bus.in_ready), 32'd1);
      tick();
      tick();
      reset  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.out_valid) pulses++;
      end
      check("arst_no_valid", 32'(pulses), 32'd0);

      bus.op       = OP_ADD;
      bus.in1      = 8'h02;
      bus.in2      = 8'h03;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("post_rst_valid", 32'(bus.out_valid), 32'd1);
      check("post_rst_out", 32'(bus.out), 32'h05);
      check("post_rst_flags", 32'(bus.flags), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
